pipe_controller: RTL and testbench
==================================

# pipe_controller

Parametrised pipelined control unit for the 5-stage MIPS core. It decodes op/funct/rs/rt in D and carries a control bundle through E, M and W pipeline registers, with per-stage stall/flush. It also runs a multi-cycle DIV/DIVU sequencer that holds the divide in E and requests a front-end stall. It sits beside the datapath and hazard unit and replaces the purely combinational decoder.

## Interface
Parameters:
- `ALUCTRL_W`, 8: width of the ALU control code.
- `DIV_CYCLES`, 32: E-stage residency of DIV/DIVU in cycles. Legal range is ≥2.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `opD`, `functD`  in  6 each  instruction fields in D.
- `rsD`, `rtD`  in  5 each  instruction fields in D.
- `stallE`, `stallM`  in  1  hazard-unit stalls.
- `flushE`, `flushM`, `flushW`  in  1  hazard-unit flushes.
- `branchD`, `jumpD`, `jumprD`, `invalidD`  out  1  D-stage decode outputs, combinational.
- `regdstE`, `alusrcE`, `write_alE`, `memtoregE`, `regwriteE`  out  1  E-stage controls.
- `alucontrolE`  out  ALUCTRL_W  E-stage ALU code.
- `memwriteM`, `memtoregM`, `regwriteM`, `cp0writeM`  out  1  M-stage controls.
- `memtoregW`, `regwriteW`  out  1  W-stage controls.
- `div_start`  out  1  one-cycle pulse when a divide begins in E.
- `div_stall`  out  1  request to the hazard unit to freeze F/D/E.

## Operation
- Decode:
  - LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03, ADDI 0x08, REGIMM 0x01 (BLTZAL/BGEZAL have rt 0x10/0x11 and set write_al).
  - R-type op 0x00 with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, JR 0x08, DIV 0x1A, DIVU 0x1B.
  - Any unlisted encoding sets invalidD=1 and decodes to an all-zero bundle.
- ALU codes: NOP 0x00, ADD 0x01, SUB 0x02, AND 0x03, OR 0x04, SLT 0x05, DIV 0x06, DIVU 0x07. Codes are zero-extended to ALUCTRL_W.
- Register update priority per stage is flush > hold > load. A flush loads the all-zero bundle.
- Effective E hold is stallE | div_stall.
- Bubble rule: when E is held and M is not stalled, M loads all-zero. When M is stalled, W loads all-zero.
- Divide FSM (states IDLE, BUSY, DONE; 5-bit-or-wider counter sized by $clog2(DIV_CYCLES)):
  - IDLE, with E holding DIV/DIVU: div_start=1, div_stall=1, counter ← DIV_CYCLES−2, go to BUSY.
  - BUSY, counter≠0: div_stall=1, decrement.
  - BUSY, counter=0: div_stall=0. Go to IDLE if !stallE, else go to DONE.
  - DONE: div_stall=0. Stay while stallE; go to IDLE on !stallE. DONE prevents a held divide from restarting.
  - flushE in any state: go to IDLE and clear the counter. div_stall and div_start are masked in that same cycle.
- DIV/DIVU write HI/LO, not the GPR file, so regwrite=0 for them.

## Timing
- Reset: every register, the FSM (IDLE) and every registered output go to 0 immediately. D outputs follow the inputs.
- Latency: D→E is 1 cycle, E→M is 1 cycle, M→W is 1 cycle.
- A divide occupies E for exactly DIV_CYCLES cycles when there is no external stall. div_stall is high for the first DIV_CYCLES−1 of them.
- div_stall and div_start are combinational from the E register and FSM state. Both are valid in the same cycle as the E contents.
- If rst asserts mid-divide, the FSM returns to IDLE with no pulse on release.

## Configuration
- `PIPE_CTRL_CP0_EN` defined:
  - Decode MTC0 (op 0x10, rs 0x04) to cp0write=1.
  - Decode MFC0 (op 0x10, rs 0x00) to regwrite=1.
  - Decode ERET (op 0x10, funct 0x18) to jump=1.
  - cp0writeM is carried through E into M.
- Not defined: op 0x10 gives invalidD=1, and cp0writeM is tied to 0.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the opcode, funct and rt constants;
  - the ALU code constants;
  - the FSM state enum;
  - a packed control-bundle struct used for all three pipeline registers.
- Sub-module `ctrl_decode` is the combinational D-stage decode into a bundle. The top level holds the registers and the FSM.

## Test plan
- Async reset while regwriteW=1 and the FSM is BUSY → all registered outputs are 0 and the FSM is IDLE before the next clk edge.
- LW in D, no stalls → next cycle memtoregE=1, alusrcE=1, alucontrolE=0x01. +2 cycles: memtoregM=1. +3 cycles: memtoregW=1, regwriteW=1.
- DIV with DIV_CYCLES=4 → alucontrolE=0x06 for 4 cycles, div_start high on cycle 1 only, div_stall high on cycles 1–3, M receives 3 bubbles.
- DIV with flushE on its 2nd cycle in E → div_stall=0 from the next cycle, E=0, FSM IDLE. A following DIV restarts with a new div_start.
- DIV with stallE held for 2 cycles after the counter expires → FSM is in DONE, div_start is not re-asserted, E advances when stallE drops.
- op 0x3F → invalidD=1 and the next cycle's E bundle is all zero. MTC0 → cp0writeM=1 two cycles later with PIPE_CTRL_CP0_EN; without it, invalidD=1 and cp0writeM=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings, ALU codes, divide FSM states and the control bundle carried
// through the E, M and W pipeline registers of pipe_controller.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_COP0   = 6'h10;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_ERET   = 6'h18;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_DIVU   = 6'h1B;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam logic [5:0] FN_SLT    = 6'h2A;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;
    localparam logic [4:0] RS_MFC0   = 5'h00;
    localparam logic [4:0] RS_MTC0   = 5'h04;

    typedef enum logic [2:0] {
        ALU_NOP  = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_SLT  = 3'd5,
        ALU_DIV  = 3'd6,
        ALU_DIVU = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic    regdst;
        logic    alusrc;
        logic    write_al;
        logic    memtoreg;
        logic    regwrite;
        logic    memwrite;
        logic    cp0write;
        logic    branch;
        logic    jump;
        logic    jumpr;
        alu_op_t aluop;
    } ctrl_bundle_t;

    function automatic logic is_div(input alu_op_t op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational D-stage decode of op/funct/rs/rt into a control bundle.
// COP0 instructions are decoded only when PIPE_CTRL_CP0_EN is defined.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    input  logic [4:0]   rs,
    input  logic [4:0]   rt,
    output ctrl_bundle_t ctrl,
    output logic         invalid
);

    ctrl_bundle_t dec_s;
    logic         inv_s;

    // Raw decode; unknown encodings raise inv_s and are zeroed below.
    always_comb begin
        dec_s = '0;
        inv_s = 1'b0;
        case (op)
            OP_LW:   begin dec_s.regwrite = 1'b1; dec_s.memtoreg = 1'b1; dec_s.alusrc = 1'b1; dec_s.aluop = ALU_ADD; end
            OP_SW:   begin dec_s.memwrite = 1'b1; dec_s.alusrc = 1'b1; dec_s.aluop = ALU_ADD; end
            OP_BEQ,
            OP_BNE:  begin dec_s.branch = 1'b1; dec_s.aluop = ALU_SUB; end
            OP_J:    dec_s.jump = 1'b1;
            OP_JAL:  begin dec_s.jump = 1'b1; dec_s.regwrite = 1'b1; dec_s.write_al = 1'b1; end
            OP_ADDI: begin dec_s.regwrite = 1'b1; dec_s.alusrc = 1'b1; dec_s.aluop = ALU_ADD; end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ:     dec_s.branch = 1'b1;
                    RT_BLTZAL, RT_BGEZAL: begin dec_s.branch = 1'b1; dec_s.regwrite = 1'b1; dec_s.write_al = 1'b1; end
                    default:              inv_s = 1'b1;
                endcase
            end
            OP_RTYPE: begin
                dec_s.regdst   = 1'b1;
                dec_s.regwrite = 1'b1;
                case (funct)
                    FN_ADD:  dec_s.aluop = ALU_ADD;
                    FN_SUB:  dec_s.aluop = ALU_SUB;
                    FN_AND:  dec_s.aluop = ALU_AND;
                    FN_OR:   dec_s.aluop = ALU_OR;
                    FN_SLT:  dec_s.aluop = ALU_SLT;
                    FN_JR:   begin dec_s.jumpr = 1'b1; dec_s.regdst = 1'b0; dec_s.regwrite = 1'b0; end
                    // Divides target HI/LO, never the GPR file.
                    FN_DIV:  begin dec_s.aluop = ALU_DIV; dec_s.regdst = 1'b0; dec_s.regwrite = 1'b0; end
                    FN_DIVU: begin dec_s.aluop = ALU_DIVU; dec_s.regdst = 1'b0; dec_s.regwrite = 1'b0; end
                    default: inv_s = 1'b1;
                endcase
            end
`ifdef PIPE_CTRL_CP0_EN
            OP_COP0: begin
                if (rs == RS_MTC0) begin
                    dec_s.cp0write = 1'b1;
                end else if (rs == RS_MFC0) begin
                    dec_s.regwrite = 1'b1;
                end else if (funct == FN_ERET) begin
                    dec_s.jump = 1'b1;
                end else begin
                    inv_s = 1'b1;
                end
            end
`endif
            default: inv_s = 1'b1;
        endcase
    end

`ifndef PIPE_CTRL_CP0_EN
    logic unused_rs_s;
    assign unused_rs_s = ^rs;
`endif

    assign ctrl    = inv_s ? ctrl_bundle_t'('0) : dec_s;
    assign invalid = inv_s;

endmodule

// File: rtl/pipe_controller.sv
// Pipelined MIPS control: D decode, E/M/W control registers and DIV/DIVU sequencer.
// Define PIPE_CTRL_CP0_EN to decode MTC0/MFC0/ERET and carry cp0write to M.
module pipe_controller
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 8,
    parameter int DIV_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opD,
    input  logic [5:0]           functD,
    input  logic [4:0]           rsD,
    input  logic [4:0]           rtD,
    input  logic                 stallE,
    input  logic                 stallM,
    input  logic                 flushE,
    input  logic                 flushM,
    input  logic                 flushW,
    output logic                 branchD,
    output logic                 jumpD,
    output logic                 jumprD,
    output logic                 invalidD,
    output logic                 regdstE,
    output logic                 alusrcE,
    output logic                 write_alE,
    output logic                 memtoregE,
    output logic                 regwriteE,
    output logic [ALUCTRL_W-1:0] alucontrolE,
    output logic                 memwriteM,
    output logic                 memtoregM,
    output logic                 regwriteM,
    output logic                 cp0writeM,
    output logic                 memtoregW,
    output logic                 regwriteW,
    output logic                 div_start,
    output logic                 div_stall
);

    localparam int CNT_W = ($clog2(DIV_CYCLES) > 5) ? $clog2(DIV_CYCLES) : 5;
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    ctrl_bundle_t     dec_s, e_r, m_r, w_r;
    logic             inv_s, hold_e_s, div_start_s, div_stall_s;
    div_state_t       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

    ctrl_decode u_decode (
        .op      (opD),
        .funct   (functD),
        .rs      (rsD),
        .rt      (rtD),
        .ctrl    (dec_s),
        .invalid (inv_s)
    );

    // Divide sequencer next state; a flush aborts and masks both requests.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        div_start_s = 1'b0;
        div_stall_s = 1'b0;
        if (flushE) begin
            state_nxt_s = DIV_IDLE;
            cnt_nxt_s   = '0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (is_div(e_r.aluop)) begin
                        div_start_s = 1'b1;
                        div_stall_s = 1'b1;
                        cnt_nxt_s   = DIV_LOAD;
                        state_nxt_s = DIV_BUSY;
                    end else begin
                        state_nxt_s = DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    if (cnt_r != '0) begin
                        div_stall_s = 1'b1;
                        cnt_nxt_s   = cnt_r - CNT_W'(1);
                    end else if (stallE) begin
                        state_nxt_s = DIV_DONE;
                    end else begin
                        state_nxt_s = DIV_IDLE;
                    end
                end
                // DONE keeps an externally held divide from starting again.
                DIV_DONE: begin
                    if (stallE) begin
                        state_nxt_s = DIV_DONE;
                    end else begin
                        state_nxt_s = DIV_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = DIV_IDLE;
                    cnt_nxt_s   = '0;
                end
            endcase
        end
    end

    assign hold_e_s = stallE | div_stall_s;

    // Divide sequencer state and countdown registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DIV_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // E register: flush, then hold, then load from decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_r <= '0;
        end else if (flushE) begin
            e_r <= '0;
        end else if (hold_e_s) begin
            e_r <= e_r;
        end else begin
            e_r <= dec_s;
        end
    end

    // M register: a held E with M free injects a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r <= '0;
        end else if (flushM) begin
            m_r <= '0;
        end else if (stallM) begin
            m_r <= m_r;
        end else if (hold_e_s) begin
            m_r <= '0;
        end else begin
            m_r <= e_r;
        end
    end

    // W register: a stalled M injects a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_r <= '0;
        end else if (flushW) begin
            w_r <= '0;
        end else if (stallM) begin
            w_r <= '0;
        end else begin
            w_r <= m_r;
        end
    end

    logic unused_w_s;
    assign unused_w_s = ^w_r;

    assign branchD     = dec_s.branch;
    assign jumpD       = dec_s.jump;
    assign jumprD      = dec_s.jumpr;
    assign invalidD    = inv_s;
    assign regdstE     = e_r.regdst;
    assign alusrcE     = e_r.alusrc;
    assign write_alE   = e_r.write_al;
    assign memtoregE   = e_r.memtoreg;
    assign regwriteE   = e_r.regwrite;
    assign alucontrolE = ALUCTRL_W'(e_r.aluop);
    assign memwriteM   = m_r.memwrite;
    assign memtoregM   = m_r.memtoreg;
    assign regwriteM   = m_r.regwrite;
`ifdef PIPE_CTRL_CP0_EN
    assign cp0writeM   = m_r.cp0write;
`else
    assign cp0writeM   = 1'b0;
`endif
    assign memtoregW   = w_r.memtoreg;
    assign regwriteW   = w_r.regwrite;
    assign div_start   = div_start_s;
    assign div_stall   = div_stall_s;

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller (DIV_CYCLES=4): directed scenarios plus
// randomized traffic against a behavioural pipeline/divide model.
module tb_pipe_controller;

    localparam int ALUCTRL_W  = 8;
    localparam int DIV_CYCLES = 4;
    localparam logic [5:0] OP_BAD = 6'h3F;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] opD, functD;
    logic [4:0] rsD, rtD;
    logic stallE, stallM, flushE, flushM, flushW;
    logic branchD, jumpD, jumprD, invalidD;
    logic regdstE, alusrcE, write_alE, memtoregE, regwriteE;
    logic [ALUCTRL_W-1:0] alucontrolE;
    logic memwriteM, memtoregM, regwriteM, cp0writeM, memtoregW, regwriteW;
    logic div_start, div_stall;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_controller #(.ALUCTRL_W(ALUCTRL_W), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst(rst), .opD(opD), .functD(functD), .rsD(rsD), .rtD(rtD),
        .stallE(stallE), .stallM(stallM), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .branchD(branchD), .jumpD(jumpD), .jumprD(jumprD), .invalidD(invalidD),
        .regdstE(regdstE), .alusrcE(alusrcE), .write_alE(write_alE), .memtoregE(memtoregE),
        .regwriteE(regwriteE), .alucontrolE(alucontrolE), .memwriteM(memwriteM),
        .memtoregM(memtoregM), .regwriteM(regwriteM), .cp0writeM(cp0writeM),
        .memtoregW(memtoregW), .regwriteW(regwriteW), .div_start(div_start), .div_stall(div_stall)
    );

    typedef struct packed {
        logic regdst, alusrc, write_al, memtoreg, regwrite, memwrite, cp0write, branch, jump, jumpr;
        logic [7:0] alu;
    } tb_ctl_t;

    wire [12:0] act_e   = {regdstE, alusrcE, write_alE, memtoregE, regwriteE, alucontrolE};
    wire [3:0]  act_m   = {memwriteM, memtoregM, regwriteM, cp0writeM};
    wire [1:0]  act_w   = {memtoregW, regwriteW};
    wire [3:0]  act_d   = {branchD, jumpD, jumprD, invalidD};
    wire [1:0]  act_div = {div_start, div_stall};

    // Reference model state: stage contents plus divide residency bookkeeping.
    tb_ctl_t me, mm, mw, md;
    logic    md_inv;
    logic    exp_start, exp_stall;
    int      div_age;
    bit      div_fin;

    function automatic tb_ctl_t ref_decode(input logic [5:0] op, input logic [5:0] funct,
                                           input logic [4:0] rs, input logic [4:0] rt,
                                           output logic inv);
        tb_ctl_t c;
        c = '0;
        inv = 1'b0;
        case (op)
            6'h23: begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.alusrc = 1'b1; c.alu = 8'h01; end
            6'h2B: begin c.memwrite = 1'b1; c.alusrc = 1'b1; c.alu = 8'h01; end
            6'h04, 6'h05: begin c.branch = 1'b1; c.alu = 8'h02; end
            6'h02: c.jump = 1'b1;
            6'h03: begin c.jump = 1'b1; c.regwrite = 1'b1; c.write_al = 1'b1; end
            6'h08: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.alu = 8'h01; end
            6'h01: begin
                if (rt == 5'h00 || rt == 5'h01) c.branch = 1'b1;
                else if (rt == 5'h10 || rt == 5'h11) begin
                    c.branch = 1'b1; c.regwrite = 1'b1; c.write_al = 1'b1;
                end else inv = 1'b1;
            end
            6'h00: begin
                case (funct)
                    6'h20: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.alu = 8'h01; end
                    6'h22: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.alu = 8'h02; end
                    6'h24: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.alu = 8'h03; end
                    6'h25: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.alu = 8'h04; end
                    6'h2A: begin c.regdst = 1'b1; c.regwrite = 1'b1; c.alu = 8'h05; end
                    6'h08: c.jumpr = 1'b1;
                    6'h1A: c.alu = 8'h06;
                    6'h1B: c.alu = 8'h07;
                    default: inv = 1'b1;
                endcase
            end
            6'h10: begin
`ifdef PIPE_CTRL_CP0_EN
                if (rs == 5'h04) c.cp0write = 1'b1;
                else if (rs == 5'h00) c.regwrite = 1'b1;
                else if (funct == 6'h18) c.jump = 1'b1;
                else inv = 1'b1;
`else
                inv = 1'b1;
`endif
            end
            default: inv = 1'b1;
        endcase
        if (inv) c = '0;
        return c;
    endfunction

    function automatic bit alu_is_div(input logic [7:0] a);
        return (a == 8'h06) || (a == 8'h07);
    endfunction

    function automatic logic [12:0] exp_e();
        return {me.regdst, me.alusrc, me.write_al, me.memtoreg, me.regwrite, me.alu};
    endfunction

    task automatic model_reset();
        me = '0; mm = '0; mw = '0; div_age = 0; div_fin = 1'b0;
    endtask

    // Evaluate combinational expectations for the inputs currently applied.
    task automatic settle();
        #1;
        md = ref_decode(opD, functD, rsD, rtD, md_inv);
        exp_start = 1'b0;
        exp_stall = 1'b0;
        if (!rst && !flushE && alu_is_div(me.alu) && !div_fin) begin
            exp_start = (div_age == 0);
            exp_stall = (div_age + 1 < DIV_CYCLES);
        end
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] ctl);
        opD = op; functD = fn; rsD = rs; rtD = rt;
        {stallE, stallM, flushE, flushM, flushW} = ctl;
    endtask

    task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] ctl);
        @(negedge clk);
        set_in(op, fn, rs, rt, ctl);
        settle();
    endtask

    // Advance the model across one rising edge, in step with the DUT.
    task automatic step();
        tb_ctl_t ne, nm, nw;
        int na;
        bit nf, hold;
        hold = stallE | exp_stall;
        if (flushE) ne = '0; else if (hold) ne = me; else ne = md;
        if (flushM) nm = '0; else if (stallM) nm = mm; else if (hold) nm = '0; else nm = me;
        if (flushW || stallM) nw = '0; else nw = mm;
        na = div_age;
        nf = div_fin;
        if (flushE) begin
            na = 0; nf = 1'b0;
        end else if (alu_is_div(me.alu) && !div_fin) begin
            if (div_age + 1 >= DIV_CYCLES) begin na = 0; nf = stallE; end
            else na = div_age + 1;
        end else if (div_fin && !stallE) begin
            nf = 1'b0;
        end
        @(posedge clk);
        me = ne; mm = nm; mw = nw; div_age = na; div_fin = nf;
        #1;
    endtask

    task automatic test_reset();
        set_in(6'h04, 6'h00, 5'd0, 5'd0, 5'b00000);
        #2;
        settle();
        n_checks++;
        if ({act_e, act_m, act_w, act_div} !== 21'd0) $display("FAIL reset_state got %h want 0", {act_e, act_m, act_w, act_div});
        else n_pass++;
        n_checks++;
        if (act_d !== 4'b1000) $display("FAIL reset_d_follows got %b want 1000", act_d);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        set_in(6'h08, 6'h00, 5'd0, 5'd0, 5'b00000);
        settle();
        step();
        apply(6'h00, 6'h1A, 5'd0, 5'd0, 5'b00000); step();
        apply(6'h00, 6'h20, 5'd0, 5'd0, 5'b00000); step();
        n_checks++;
        if ({regwriteW, div_stall} !== 2'b11) $display("FAIL reset_setup got %b want 11", {regwriteW, div_stall});
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({act_e, act_m, act_w, act_div} !== 21'd0) $display("FAIL reset_async got %h want 0", {act_e, act_m, act_w, act_div});
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set_in(OP_BAD, 6'h00, 5'd0, 5'd0, 5'b00000);
        settle();
        n_checks++;
        if (act_div !== 2'b00) $display("FAIL reset_no_pulse got %b want 00", act_div);
        else n_pass++;
        step();
    endtask

    task automatic test_lw();
        apply(6'h23, 6'h00, 5'd1, 5'd2, 5'b00000);
        n_checks++;
        if (invalidD !== 1'b0) $display("FAIL lw_invalidD got %b want 0", invalidD);
        else n_pass++;
        step();
        apply(OP_BAD, 6'h00, 5'd0, 5'd0, 5'b00000);
        n_checks++;
        if ({memtoregE, alusrcE, alucontrolE} !== {1'b1, 1'b1, 8'h01})
            $display("FAIL lw_E got %b %b %h want 1 1 01", memtoregE, alusrcE, alucontrolE);
        else n_pass++;
        step();
        apply(OP_BAD, 6'h00, 5'd0, 5'd0, 5'b00000);
        n_checks++;
        if (memtoregM !== 1'b1) $display("FAIL lw_M got %b want 1", memtoregM);
        else n_pass++;
        step();
        apply(OP_BAD, 6'h00, 5'd0, 5'd0, 5'b00000);
        n_checks++;
        if ({memtoregW, regwriteW} !== 2'b11) $display("FAIL lw_W got %b want 11", {memtoregW, regwriteW});
        else n_pass++;
        step();
    endtask

    task automatic test_div();
        apply(6'h00, 6'h20, 5'd0, 5'd0, 5'b00000); step();
        apply(6'h00, 6'h1A, 5'd0, 5'd0, 5'b00000); step();
        for (int k = 1; k <= 5; k++) begin
            apply(6'h00, 6'h20, 5'd0, 5'd0, 5'b00000);
            n_checks++;
            if (alucontrolE !== ((k <= 4) ? 8'h06 : 8'h01)) $display("FAIL div_alu c%0d got %h", k, alucontrolE);
            else n_pass++;
            n_checks++;
            if (act_div !== {k == 1, k <= 3}) $display("FAIL div_ctrl c%0d got %b want %b", k, act_div, {k == 1, k <= 3});
            else n_pass++;
            n_checks++;
            if (regwriteM !== (k == 1)) $display("FAIL div_bubble c%0d got %b want %b", k, regwriteM, k == 1);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_div_flush();
        apply(6'h00, 6'h1A, 5'd0, 5'd0, 5'b00000); step();
        apply(OP_BAD, 6'h00, 5'd0, 5'd0, 5'b00000);
        n_checks++;
        if (act_div !== 2'b11) $display("FAIL dflush_start got %b want 11", act_div);
        else n_pass++;
        step();
        apply(OP_BAD, 6'h00, 5'd0, 5'd0, 5'b00100);
        n_checks++;
        if (act_div !== 2'b00) $display("FAIL dflush_mask got %b want 00", act_div);
        else n_pass++;
        step();
        apply(6'h00, 6'h1B, 5'd0, 5'd0, 5'b00000);
        n_checks++;
        if ({alucontrolE, act_div} !== 10'd0) $display("FAIL dflush_after got %h %b want 00 00", alucontrolE, act_div);
        else n_pass++;
        step();
        apply(OP_BAD, 6'h00, 5'd0, 5'd0, 5'b00000);
        n_checks++;
        if ({alucontrolE, act_div} !== {8'h07, 2'b11}) $display("FAIL dflush_restart got %h %b want 07 11", alucontrolE, act_div);
        else n_pass++;
        step();
        for (int k = 0; k < DIV_CYCLES + 1; k++) begin
            apply(OP_BAD, 6'h00, 5'd0, 5'd0, 5'b00000); step();
        end
    endtask

    task automatic test_div_done();
        logic [4:0] ctl;
        apply(6'h00, 6'h1A, 5'd0, 5'd0, 5'b00000); step();
        for (int k = 1; k <= 7; k++) begin
            ctl = (k == 4 || k == 5) ? 5'b10000 : 5'b00000;
            apply(6'h00, 6'h20, 5'd0, 5'd0, ctl);
            n_checks++;
            if (alucontrolE !== ((k <= 6) ? 8'h06 : 8'h01)) $display("FAIL done_alu c%0d got %h", k, alucontrolE);
            else n_pass++;
            n_checks++;
            if (act_div !== {k == 1, k <= 3}) $display("FAIL done_ctrl c%0d got %b want %b", k, act_div, {k == 1, k <= 3});
            else n_pass++;
            step();
        end
    endtask

    task automatic test_invalid_cp0();
        logic want_inv, want_cp0;
`ifdef PIPE_CTRL_CP0_EN
        want_inv = 1'b0; want_cp0 = 1'b1;
`else
        want_inv = 1'b1; want_cp0 = 1'b0;
`endif
        apply(6'h00, 6'h22, 5'd0, 5'd0, 5'b00000); step();
        apply(OP_BAD, 6'($urandom), 5'($urandom), 5'($urandom), 5'b00000);
        n_checks++;
        if (invalidD !== 1'b1) $display("FAIL inv_flag got %b want 1", invalidD);
        else n_pass++;
        step();
        apply(6'h10, 6'h00, 5'h04, 5'd3, 5'b00000);
        n_checks++;
        if (act_e !== 13'd0) $display("FAIL inv_bundle got %h want 0", act_e);
        else n_pass++;
        n_checks++;
        if (invalidD !== want_inv) $display("FAIL mtc0_invalid got %b want %b", invalidD, want_inv);
        else n_pass++;
        step();
        apply(OP_BAD, 6'h00, 5'd0, 5'd0, 5'b00000); step();
        apply(OP_BAD, 6'h00, 5'd0, 5'd0, 5'b00000);
        n_checks++;
        if (cp0writeM !== want_cp0) $display("FAIL mtc0_M got %b want %b", cp0writeM, want_cp0);
        else n_pass++;
        step();
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        logic [4:0] rs, rt, ctl;
        for (int i = 0; i < 400; i++) begin
            op = 6'($urandom); fn = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom);
            case ($urandom_range(0, 12))
                0: op = 6'h23;  1: op = 6'h2B;  2: op = 6'h04;  3: op = 6'h05;
                4: op = 6'h02;  5: op = 6'h03;  6: op = 6'h08;
                7: begin op = 6'h01; if ($urandom_range(0, 3) != 0) rt = {$urandom_range(0, 1) == 1, 3'b000, 1'($urandom)}; end
                8: begin op = 6'h00; if ($urandom_range(0, 3) != 0) fn = {1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 5))}; end
                9, 10: begin op = 6'h00; fn = {5'b01101, 1'($urandom)}; end
                11: begin op = 6'h10; rs = (($urandom_range(0, 2) == 0) ? 5'h10 : {2'b00, 1'($urandom), 2'b00}); fn = 6'h18; end
                default: op = 6'($urandom);
            endcase
            ctl = {$urandom_range(0, 6) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                   $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0};
            apply(op, fn, rs, rt, ctl);
            n_checks++;
            if (act_d !== {md.branch, md.jump, md.jumpr, md_inv}) $display("FAIL rnd_D i%0d got %b want %b", i, act_d, {md.branch, md.jump, md.jumpr, md_inv});
            else n_pass++;
            n_checks++;
            if (act_e !== exp_e()) $display("FAIL rnd_E i%0d got %h want %h", i, act_e, exp_e());
            else n_pass++;
            n_checks++;
            if (act_m !== {mm.memwrite, mm.memtoreg, mm.regwrite, mm.cp0write}) $display("FAIL rnd_M i%0d got %b want %b", i, act_m, {mm.memwrite, mm.memtoreg, mm.regwrite, mm.cp0write});
            else n_pass++;
            n_checks++;
            if (act_w !== {mw.memtoreg, mw.regwrite}) $display("FAIL rnd_W i%0d got %b want %b", i, act_w, {mw.memtoreg, mw.regwrite});
            else n_pass++;
            n_checks++;
            if (act_div !== {exp_start, exp_stall}) $display("FAIL rnd_div i%0d got %b want %b", i, act_div, {exp_start, exp_stall});
            else n_pass++;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(OP_BAD, 6'h00, 5'd0, 5'd0, 5'b00000);
        model_reset();
        test_reset();
        test_lw();
        test_div();
        test_div_flush();
        test_div_done();
        test_invalid_cp0();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
